pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
- Central sequencing unit for the single-core 5-stage pipeline.
- Decides each cycle whether the pipeline advances (pipeline_ctrl) and whether the PC holds for a load-use bubble (PCWrite). Drives per-latch enables and flushes, and arbitrates the MEM-stage data-memory request.
- Merges redirect flushes from the PC next-state logic with its own hazard bubbles, and owns the halt sequence.
- One instance per core; sits beside the program counter and the pipeline latches.

Parameters:
STALL_CNT_W, 16, width of the saturating stall-cycle counter
HALT_ON_RESET, 0, if 1 the block leaves reset in HALTED (used for idle second core)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
ihit  in  1  instruction memory returned valid instr this cycle
dhit  in  1  data memory completed current request
memread_MEM  in  1  instr in MEM is a load or LR
memwrite_MEM  in  1  instr in MEM is a store or SC
halt_MEM  in  1  instr in MEM is HALT
memread_EX  in  1  instr in EX is a load
rd_EX  in  5  destination reg of EX instr
rs1_ID  in  5  source 1 of ID instr
rs2_ID  in  5  source 2 of ID instr
flush_IF_ID_pc  in  1  redirect flush from PC logic
flush_ID_EX_pc  in  1  redirect flush from PC logic
flush_EX_MEM_pc  in  1  redirect flush from PC logic
pipeline_ctrl  out  1  global advance strobe to PC and latches
PCWrite  out  1  1 = hold PC (load-use bubble)
en_IF_ID  out  1  IF/ID latch enable
en_ID_EX, en_EX_MEM, en_MEM_WB  out  1 each  latch enables
flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  latch clear (bubble insert)
dREN  out  1  data read request
dWEN  out  1  data write request
halt  out  1  core halted
stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- FSM states: RUN, DWAIT, DDONE, HALTED. Reset: RUN (HALTED if HALT_ON_RESET=1), stall_cnt=0. All outputs combinational from state and inputs. In reset cycle, pipeline_ctrl=0, dREN=dWEN=0, halt=HALT_ON_RESET.
- mem_op = memread_MEM | memwrite_MEM.
- dmem_ok = !mem_op | dhit | (state==DDONE).
- pipeline_ctrl = ihit & dmem_ok & (state!=HALTED).
- dREN = memread_MEM & (state in RUN, DWAIT). dWEN = memwrite_MEM & (state in RUN, DWAIT). Never asserted in DDONE or HALTED, so an access is never re-issued.
- Transitions:
  - RUN -> DWAIT: mem_op & !dhit.
  - RUN/DWAIT -> DDONE: dhit & !ihit, i.e. data done but fetch outstanding.
  - RUN/DWAIT/DDONE -> RUN: pipeline_ctrl & !halt_MEM.
  - Any -> HALTED: pipeline_ctrl & halt_MEM.
  - HALTED is sticky until RST.
- Load-use hazard lu = memread_EX & (rd_EX!=0) & (rd_EX==rs1_ID | rd_EX==rs2_ID).
- redirect = any flush_*_pc.
- Outputs when pipeline_ctrl=1:
  - PCWrite = lu & !redirect. A redirect always wins; the PC must take the branch/jump target.
  - en_IF_ID = !PCWrite; other enables = 1.
  - flush_IF_ID = flush_IF_ID_pc.
  - flush_ID_EX = flush_ID_EX_pc | PCWrite.
  - flush_EX_MEM = flush_EX_MEM_pc.
- Outputs when pipeline_ctrl=0: all enables 0, all flushes 0, PCWrite=0. Redirect inputs are ignored and must be re-presented by the PC logic, which holds them because the MEM/EX latches are frozen.
- halt = (state==HALTED).
- stall_cnt increments when !pipeline_ctrl & state!=HALTED & !RST; saturates at all-ones, no wrap.
- Reset mid-DWAIT: state returns to RUN and dREN/dWEN drop in the cycle RST is sampled. The memory side must tolerate request withdrawal.
- ihit and dhit in the same cycle: advance directly, RUN/DWAIT -> RUN; DDONE never entered.

Decomposition:
- cpu_types_pkg gains pipe_state_t, an enum covering RUN, DWAIT, DDONE and HALTED.
- regbits_t (5-bit) is reused from cpu_types_pkg for the register-index ports.
- Sub-module hazard_detect (pure combinational): computes lu. It is kept separate for reuse by a forwarding unit.
- Stall counter stays inline.

Test Plan:
- Reset with HALT_ON_RESET=0, ihit=1, no mem_op -> pipeline_ctrl=1 every cycle, all enables 1, stall_cnt=0.
- memread_MEM=1, dhit low 3 cycles then high, ihit=1 -> dREN=1 for 4 cycles, pipeline_ctrl=0 for 3, then 1. stall_cnt=3.
- dhit=1 at cycle 0 with ihit=0 until cycle 2 -> state DDONE at cycles 1-2, dREN=0 in DDONE, pipeline_ctrl=1 at cycle 2 only.
- memread_EX=1, rd_EX=5, rs2_ID=5, ihit=1 -> PCWrite=1, en_IF_ID=0, flush_ID_EX=1. Repeat with rd_EX=0 -> PCWrite=0.
- Same load-use plus flush_IF_ID_pc=flush_ID_EX_pc=1 -> PCWrite=0, flush_IF_ID=1, flush_ID_EX=1.
- halt_MEM=1 with ihit=1 -> halt=1 next cycle, pipeline_ctrl stays 0 for 100 cycles, stall_cnt frozen. RST=1 -> halt=0 next cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared CPU types: register index and pipeline controller states.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DDONE  = 2'd2,
    HALTED = 2'd3
  } pipe_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/pipeline_controller_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module : hazard_detect
// Brief  : Combinational load-use hazard detection between EX and ID.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     memread_ex_i,
  input  regbits_t rd_ex_i,
  input  regbits_t rs1_id_i,
  input  regbits_t rs2_id_i,
  output logic     lu_o
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu_o = memread_ex_i && (rd_ex_i != '0) &&
                ((rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i));

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module : pipeline_controller
// Brief  : Advance/stall/flush sequencing, dmem arbitration and halt for the
//          5-stage pipeline.
// Rev    : 1.0  initial release
// ============================================================================
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int STALL_CNT_W   = 16,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   memread_MEM,
  input  logic                   memwrite_MEM,
  input  logic                   halt_MEM,
  input  logic                   memread_EX,
  input  regbits_t               rd_EX,
  input  regbits_t               rs1_ID,
  input  regbits_t               rs2_ID,
  input  logic                   flush_IF_ID_pc,
  input  logic                   flush_ID_EX_pc,
  input  logic                   flush_EX_MEM_pc,
  output logic                   pipeline_ctrl,
  output logic                   PCWrite,
  output logic                   en_IF_ID,
  output logic                   en_ID_EX,
  output logic                   en_EX_MEM,
  output logic                   en_MEM_WB,
  output logic                   flush_IF_ID,
  output logic                   flush_ID_EX,
  output logic                   flush_EX_MEM,
  output logic                   dREN,
  output logic                   dWEN,
  output logic                   halt,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_t            state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   lu;
  logic                   mem_op;
  logic                   dmem_ok;
  logic                   redirect;
  logic                   req_phase;

  hazard_detect u_hazard_detect (
    .memread_ex_i (memread_EX),
    .rd_ex_i      (rd_EX),
    .rs1_id_i     (rs1_ID),
    .rs2_id_i     (rs2_ID),
    .lu_o         (lu)
  );

  assign mem_op    = memread_MEM | memwrite_MEM;
  assign dmem_ok   = !mem_op | dhit | (state_q == DDONE);
  assign redirect  = flush_IF_ID_pc | flush_ID_EX_pc | flush_EX_MEM_pc;
  assign req_phase = (state_q == RUN) || (state_q == DWAIT);

  always_comb begin
    state_d       = state_q;
    pipeline_ctrl = 1'b0;
    PCWrite       = 1'b0;
    en_IF_ID      = 1'b0;
    en_ID_EX      = 1'b0;
    en_EX_MEM     = 1'b0;
    en_MEM_WB     = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    flush_EX_MEM  = 1'b0;
    dREN          = 1'b0;
    dWEN          = 1'b0;
    halt          = (state_q == HALTED);

    if (RST) begin
      // Requests are withdrawn in the reset cycle itself, even mid-DWAIT.
      halt = HALT_ON_RESET;
    end else begin
      pipeline_ctrl = ihit & dmem_ok & (state_q != HALTED);
      dREN          = memread_MEM & req_phase;
      dWEN          = memwrite_MEM & req_phase;

      if (pipeline_ctrl) begin
        PCWrite      = lu & !redirect;
        en_IF_ID     = !(lu & !redirect);
        en_ID_EX     = 1'b1;
        en_EX_MEM    = 1'b1;
        en_MEM_WB    = 1'b1;
        flush_IF_ID  = flush_IF_ID_pc;
        flush_ID_EX  = flush_ID_EX_pc | (lu & !redirect);
        flush_EX_MEM = flush_EX_MEM_pc;
      end

      case (state_q)
        RUN, DWAIT: begin
          if (pipeline_ctrl)
            state_d = halt_MEM ? HALTED : RUN;
          else if (dhit && !ihit)
            state_d = DDONE;
          else if (mem_op && !dhit)
            state_d = DWAIT;
        end
        DDONE: begin
          if (pipeline_ctrl)
            state_d = halt_MEM ? HALTED : RUN;
        end
        HALTED:  state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HALT_ON_RESET ? HALTED : RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating: holds at all-ones instead of wrapping back to zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else if (!pipeline_ctrl && (state_q != HALTED) && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule : pipeline_controller
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_pipeline_controller
// Brief  : Scoreboarded random + directed bench for pipeline_controller.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipeline_controller;

  localparam int C_W = 4;

  logic           CLK = 1'b0;
  logic           RST, ihit, dhit, memread_MEM, memwrite_MEM, halt_MEM, memread_EX;
  logic [4:0]     rd_EX, rs1_ID, rs2_ID;
  logic           flush_IF_ID_pc, flush_ID_EX_pc, flush_EX_MEM_pc;
  logic           pipeline_ctrl, PCWrite, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
  logic           flush_IF_ID, flush_ID_EX, flush_EX_MEM, dREN, dWEN, halt;
  logic [C_W-1:0] stall_cnt;

  always #5 CLK = ~CLK;

  pipeline_controller #(.STALL_CNT_W(C_W), .HALT_ON_RESET(1'b0)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM), .halt_MEM(halt_MEM),
    .memread_EX(memread_EX), .rd_EX(rd_EX), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .flush_IF_ID_pc(flush_IF_ID_pc), .flush_ID_EX_pc(flush_ID_EX_pc),
    .flush_EX_MEM_pc(flush_EX_MEM_pc),
    .pipeline_ctrl(pipeline_ctrl), .PCWrite(PCWrite), .en_IF_ID(en_IF_ID),
    .en_ID_EX(en_ID_EX), .en_EX_MEM(en_EX_MEM), .en_MEM_WB(en_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
    .dREN(dREN), .dWEN(dWEN), .halt(halt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    int             cyc;
    logic [11:0]    outs;
    logic [C_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: only "data already completed" and "halted" matter to
  // the outputs; waiting vs running is indistinguishable from outside.
  bit             m_halted = 1'b0;
  bit             m_ddone  = 1'b0;
  logic [C_W-1:0] m_cnt    = '0;

  function automatic logic [11:0] predict();
    bit adv, lu, redir, pcw;
    if (RST) return 12'b0;
    adv   = ihit && (!(memread_MEM || memwrite_MEM) || dhit || m_ddone) && !m_halted;
    lu    = memread_EX && rd_EX != 0 && (rd_EX == rs1_ID || rd_EX == rs2_ID);
    redir = flush_IF_ID_pc || flush_ID_EX_pc || flush_EX_MEM_pc;
    pcw   = adv && lu && !redir;
    return {adv, pcw, adv && !pcw, adv, adv, adv,
            adv && flush_IF_ID_pc, adv && (flush_ID_EX_pc || pcw), adv && flush_EX_MEM_pc,
            memread_MEM && !m_ddone && !m_halted, memwrite_MEM && !m_ddone && !m_halted,
            m_halted};
  endfunction

  task automatic step();
    exp_t e;
    bit   adv;
    e.cyc  = cyc;
    e.outs = predict();
    e.cnt  = m_cnt;
    q.push_back(e);
    adv = e.outs[11];
    @(posedge CLK);
    if (RST) begin
      m_halted = 1'b0; m_ddone = 1'b0; m_cnt = '0;
    end else if (!m_halted) begin
      if (!adv && m_cnt != {C_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (adv) begin
        m_halted = halt_MEM; m_ddone = 1'b0;
      end else if (dhit && !ihit) begin
        m_ddone = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    RST = 0; ihit = 1; dhit = 0; memread_MEM = 0; memwrite_MEM = 0; halt_MEM = 0;
    memread_EX = 0; rd_EX = 0; rs1_ID = 0; rs2_ID = 0;
    flush_IF_ID_pc = 0; flush_ID_EX_pc = 0; flush_EX_MEM_pc = 0;
  endtask

  always @(negedge CLK) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [11:0] act;
      e   = q.pop_front();
      act = {pipeline_ctrl, PCWrite, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
             flush_IF_ID, flush_ID_EX, flush_EX_MEM, dREN, dWEN, halt};
      total++;
      if (act !== e.outs) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%b want=%b", e.cyc, act, e.outs);
      end
      total++;
      if (stall_cnt !== e.cnt) begin
        bad++;
        $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", e.cyc, stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    int hcnt;
    idle_inputs();
    RST = 1;
    @(posedge CLK); #1;

    // Reset, then free-running advance with no memory traffic.
    step(); step();
    RST = 0;
    repeat (4) step();

    // Load held for three cycles of dmem wait, completes on the fourth.
    memread_MEM = 1;
    repeat (3) step();
    dhit = 1; step();
    idle_inputs(); step();

    // Data completes while fetch is outstanding: DDONE for two cycles.
    memread_MEM = 1; dhit = 1; ihit = 0; step();
    dhit = 0; step();
    ihit = 1; step();
    idle_inputs(); step();

    // Load-use bubble, then same with x0 as destination.
    memread_EX = 1; rd_EX = 5; rs2_ID = 5; rs1_ID = 3; step();
    rd_EX = 0; rs2_ID = 0; step();
    // Load-use with redirect present: redirect wins.
    rd_EX = 5; rs2_ID = 5; flush_IF_ID_pc = 1; flush_ID_EX_pc = 1; step();
    idle_inputs(); step();

    // Halt, long frozen period, then reset releases it.
    halt_MEM = 1; step();
    halt_MEM = 0;
    repeat (100) step();
    RST = 1; step();
    RST = 0; repeat (2) step();

    // Randomized traffic.
    hcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      int op;
      RST          = ($urandom_range(0, 199) == 0) || (hcnt > 6);
      ihit         = ($urandom_range(0, 3) != 0);
      dhit         = $urandom_range(0, 1);
      op           = $urandom_range(0, 2);
      memread_MEM  = (op == 1);
      memwrite_MEM = (op == 2);
      halt_MEM     = ($urandom_range(0, 39) == 0);
      memread_EX   = $urandom_range(0, 1);
      rd_EX        = 5'($urandom_range(0, 3));
      rs1_ID       = 5'($urandom_range(0, 3));
      rs2_ID       = 5'($urandom_range(0, 3));
      flush_IF_ID_pc  = ($urandom_range(0, 7) == 0);
      flush_ID_EX_pc  = ($urandom_range(0, 7) == 0);
      flush_EX_MEM_pc = ($urandom_range(0, 7) == 0);
      hcnt = m_halted ? hcnt + 1 : 0;
      step();
    end
    idle_inputs();
    step();

    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge CLK);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipeline_controller
`default_nettype wire
